nco_iq_upconverter: RTL and testbench

- Sits directly downstream of the lpm_nco instance on the C5G ADA path.
- Consumes the NCO's fsin/fcos samples and a baseband I/Q symbol stream delivered over valid/ready.
- Computes s = I*cos − Q*sin, rounds and saturates the result, converts it to offset binary, and drives the 14-bit ADA DAC.
- Holds each symbol for SPS consecutive NCO samples; mutes to midscale and flags underflow when starved.

---
 rtl/nco_iq_upconverter_pkg.sv | 22 ++
 rtl/nco_iq_upconverter_if.sv | 15 +
 rtl/nco_iq_upconverter_round_sat.sv | 34 +++
 rtl/nco_iq_upconverter.sv | 136 +++++++++++++
 tb/tb_nco_iq_upconverter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/nco_iq_upconverter_pkg.sv
// Shared widths, state encoding and shift helper for the NCO I/Q upconverter.
package nco_mod_pkg;

  localparam int NCO_W_DEF = 13;
  localparam int IQ_W_DEF  = 12;
  localparam int DAC_W_DEF = 14;
  localparam int SPS_DEF   = 8;
  localparam int SPS_W_DEF = 3;
  localparam int MIDSCALE  = 1 << (DAC_W_DEF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } state_t;

  // Right shift that maps the full product-difference range onto the DAC word.
  function automatic int calc_shift(input int iq_w, input int nco_w, input int dac_w);
    return iq_w + nco_w - dac_w;
  endfunction

endpackage

// File: rtl/nco_iq_upconverter_if.sv
// Baseband symbol stream into the upconverter.
// valid/ready: a symbol moves on any cycle where sym_valid and sym_ready are both
// high; the source holds sym_i/sym_q stable while sym_valid is high and not taken,
// and sym_ready may depend combinationally on sym_valid's companion inputs.
interface nco_iq_upconverter_if #(
  parameter int IQ_W = 12
);
  logic signed [IQ_W-1:0] sym_i;
  logic signed [IQ_W-1:0] sym_q;
  logic                   sym_valid;
  logic                   sym_ready;

  modport master (output sym_i, output sym_q, output sym_valid, input  sym_ready);
  modport slave  (input  sym_i, input  sym_q, input  sym_valid, output sym_ready);
endinterface

// File: rtl/nco_iq_upconverter_round_sat.sv
// Round-half-up, arithmetic shift, saturate and offset-binary conversion.
module iq_round_sat #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 14,
  parameter int SHIFT = 11
) (
  input  logic signed [IN_W-1:0] d,
  output logic [OUT_W-1:0]       code
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] MAX_V = (SUM_W'(1) << (OUT_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - SUM_W'(1);

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] r;
  logic [OUT_W-1:0]        sat;

  always_comb begin
    sum = $signed({d[IN_W-1], d}) + HALF;
    r   = sum >>> SHIFT;
    if (r > MAX_V) begin
      sat = MAX_V[OUT_W-1:0];
    end else if (r < MIN_V) begin
      sat = MIN_V[OUT_W-1:0];
    end else begin
      sat = r[OUT_W-1:0];
    end
    code = {~sat[OUT_W-1], sat[OUT_W-2:0]};
  end

endmodule

// File: rtl/nco_iq_upconverter.sv
// Mixes held baseband symbols with NCO sin/cos (s = I*cos - Q*sin) and drives an
// offset-binary DAC through a 3-stage clken-gated pipeline; mutes when starved.
module nco_iq_upconverter
  import nco_mod_pkg::*;
#(
  parameter int NCO_W = NCO_W_DEF,
  parameter int IQ_W  = IQ_W_DEF,
  parameter int DAC_W = DAC_W_DEF,
  parameter int SPS   = SPS_DEF,
  parameter int SPS_W = SPS_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic signed [NCO_W-1:0] nco_sin,
  input  logic signed [NCO_W-1:0] nco_cos,
  input  logic                    nco_valid,
  nco_iq_upconverter_if.slave     sym,
  output logic [DAC_W-1:0]        dac_data,
  output logic                    dac_valid,
  output logic                    underflow,
  output state_t                  dbg_state
);

  localparam int P_W = IQ_W + NCO_W;
  localparam int D_W = P_W + 1;
  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [SPS_W-1:0]        cnt_q, cnt_d;
  logic signed [IQ_W-1:0]  sym_i_q, sym_i_d, sym_q_q, sym_q_d;
  logic signed [P_W-1:0]   p_i_q, p_i_d, p_q_q, p_q_d;
  logic                    v1_q, v1_d, v2_q, v2_d;
  logic signed [D_W-1:0]   d_q, d_d;
  logic [DAC_W-1:0]        dac_data_q, dac_data_d;
  logic                    dac_valid_q, dac_valid_d;

  logic                    accept, need_new, xfer;
  logic signed [IQ_W-1:0]  mul_i, mul_q;
  logic [DAC_W-1:0]        rs_code;

  assign accept        = clken & nco_valid;
  assign need_new      = (state_q != RUN) | (cnt_q == SPS_W'(SPS - 1));
  assign sym.sym_ready = accept & need_new;
  assign xfer          = sym.sym_valid & sym.sym_ready;
  // Pulses in the very cycle the starving sample is presented.
  assign underflow     = accept & (state_q == RUN) & need_new & ~xfer;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    p_i_d       = p_i_q;
    p_q_d       = p_q_q;
    v1_d        = v1_q;
    d_d         = d_q;
    v2_d        = v2_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = dac_valid_q;
    mul_i       = '0;
    mul_q       = '0;

    if (accept) begin
      if (xfer) begin
        state_d = RUN;
        cnt_d   = '0;
        sym_i_d = sym.sym_i;
        sym_q_d = sym.sym_q;
        mul_i   = sym.sym_i;
        mul_q   = sym.sym_q;
      end else if (!need_new) begin
        cnt_d = cnt_q + SPS_W'(1);
        mul_i = sym_i_q;
        mul_q = sym_q_q;
      end else if (state_q == RUN) begin
        state_d = STARVED;
      end
    end

    // Whole pipeline shares the clock enable; bubbles ride along as valid=0.
    if (clken) begin
      p_i_d       = mul_i * nco_cos;
      p_q_d       = mul_q * nco_sin;
      v1_d        = nco_valid;
      d_d         = p_i_q - p_q_q;
      v2_d        = v1_q;
      dac_valid_d = v2_q;
      if (v2_q) begin
        dac_data_d = rs_code;
      end
    end
  end

  iq_round_sat #(
    .IN_W  (D_W),
    .OUT_W (DAC_W),
    .SHIFT (calc_shift(IQ_W, NCO_W, DAC_W))
  ) u_round_sat (
    .d    (d_q),
    .code (rs_code)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      p_i_q       <= '0;
      p_q_q       <= '0;
      v1_q        <= 1'b0;
      d_q         <= '0;
      v2_q        <= 1'b0;
      dac_data_q  <= MID;
      dac_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      p_i_q       <= p_i_d;
      p_q_q       <= p_q_d;
      v1_q        <= v1_d;
      d_q         <= d_d;
      v2_q        <= v2_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
    end
  end

  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nco_iq_upconverter.sv
// Directed bench for nco_iq_upconverter: table of symbol vectors plus
// hand-written sequences for latency, starvation, clock-enable freeze and reset.
module tb_nco_iq_upconverter;
  import nco_mod_pkg::*;

  typedef struct {
    int i;
    int q;
    int s;
    int c;
    int e;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              clken;
  logic signed [12:0] nco_sin;
  logic signed [12:0] nco_cos;
  logic              nco_valid;
  logic [13:0]       dac_data;
  logic              dac_valid;
  logic              underflow;
  state_t            dbg_state;

  nco_iq_upconverter_if #(.IQ_W(12)) sym ();

  nco_iq_upconverter dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .nco_sin   (nco_sin),
    .nco_cos   (nco_cos),
    .nco_valid (nco_valid),
    .sym       (sym),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .underflow (underflow),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [13:0] exp_q[$];
  logic fresh = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: every clken=1 edge that leaves dac_valid high consumes one expectation.
  always @(posedge clk) fresh = (clken === 1'b1) && (reset === 1'b0);

  always @(negedge clk) begin
    if (fresh && dac_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("dac_valid without pending sample", 1, 0);
      end else begin
        chk("dac_data", int'(dac_data), int'(exp_q.pop_front()));
      end
    end
  end

  // Driver: present one cycle of inputs, check combinational outputs mid-cycle.
  task automatic step(input logic cke, input logic nv, input logic sv, input vec_t v,
                      input logic exp_rdy, input logic exp_uf, input string tag);
    clken         = cke;
    nco_valid     = nv;
    sym.sym_valid = sv;
    sym.sym_i     = 12'(v.i);
    sym.sym_q     = 12'(v.q);
    nco_sin       = 13'(v.s);
    nco_cos       = 13'(v.c);
    @(negedge clk);
    chk({tag, " sym_ready"}, int'(sym.sym_ready), int'(exp_rdy));
    chk({tag, " underflow"}, int'(underflow), int'(exp_uf));
    if (cke && nv) exp_q.push_back(14'(v.e));
    @(posedge clk);
    #1;
  endtask

  // One full symbol: transfer on the first sample, reuse for the remaining SPS-1.
  task automatic run_symbol(input vec_t v, input int first_k, input int last_k, input string tag);
    for (int k = first_k; k <= last_k; k++) begin
      step(1'b1, 1'b1, 1'b1, v, k == 0, 1'b0, tag);
    end
  endtask

  vec_t vecs[10];
  vec_t mute_v;
  vec_t tone_v;

  initial begin
    vecs[0] = '{i: 1024,  q: 0,     s: 0,     c: 4095,  e: 10240};
    vecs[1] = '{i: 0,     q: 1024,  s: -4096, c: 0,     e: 10240};
    vecs[2] = '{i: -2048, q: -2048, s: 4095,  c: -4096, e: 16383};
    vecs[3] = '{i: -2048, q: 0,     s: 0,     c: 4095,  e: 4097};
    vecs[4] = '{i: 1,     q: 0,     s: 0,     c: 1024,  e: 8193};
    vecs[5] = '{i: 1,     q: 0,     s: 0,     c: 1023,  e: 8192};
    vecs[6] = '{i: -1,    q: 0,     s: 0,     c: 1024,  e: 8192};
    vecs[7] = '{i: -1,    q: 0,     s: 0,     c: 1025,  e: 8191};
    vecs[8] = '{i: 2047,  q: -2048, s: -4096, c: 4095,  e: 8189};
    vecs[9] = '{i: -2048, q: -2048, s: -4096, c: 4095,  e: 1};
    mute_v  = '{i: 1000,  q: -900,  s: 3000,  c: -2000, e: MIDSCALE};
    tone_v  = vecs[0];

    reset         = 1'b1;
    clken         = 1'b0;
    nco_valid     = 1'b0;
    nco_sin       = '0;
    nco_cos       = '0;
    sym.sym_valid = 1'b0;
    sym.sym_i     = '0;
    sym.sym_q     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dac_data", int'(dac_data), MIDSCALE);
    chk("reset dac_valid", int'(dac_valid), 0);
    chk("reset underflow", int'(underflow), 0);
    chk("reset state", int'(dbg_state), int'(IDLE));
    @(posedge clk);
    #1 reset = 1'b0;

    // Exact 3-cycle latency on an idle (muted) sample, then a bubble
    step(1'b1, 1'b1, 1'b0, mute_v, 1'b1, 1'b0, "idle first");
    chk("latency +1 dac_valid", int'(dac_valid), 0);
    step(1'b1, 1'b0, 1'b0, mute_v, 1'b0, 1'b0, "bubble a");
    chk("latency +2 dac_valid", int'(dac_valid), 0);
    step(1'b1, 1'b0, 1'b0, mute_v, 1'b0, 1'b0, "bubble b");
    chk("latency +3 dac_valid", int'(dac_valid), 1);
    chk("latency +3 dac_data", int'(dac_data), MIDSCALE);
    step(1'b1, 1'b0, 1'b0, mute_v, 1'b0, 1'b0, "bubble c");
    chk("bubble dac_valid", int'(dac_valid), 0);
    chk("bubble dac_data hold", int'(dac_data), MIDSCALE);
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, mute_v, 1'b1, 1'b0, "idle");
    chk("idle state", int'(dbg_state), int'(IDLE));

    // Table: back-to-back symbols, each held for 8 samples
    foreach (vecs[v]) begin
      run_symbol(vecs[v], 0, 7, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d state", v), int'(dbg_state), int'(RUN));
    end

    // Starvation: one pulse, then quiet while starved, then resume
    step(1'b1, 1'b1, 1'b0, mute_v, 1'b1, 1'b1, "starve");
    chk("starve state", int'(dbg_state), int'(STARVED));
    step(1'b1, 1'b1, 1'b0, mute_v, 1'b1, 1'b0, "starved idle");
    chk("starved idle state", int'(dbg_state), int'(STARVED));
    run_symbol(tone_v, 0, 7, "resume");
    chk("resume state", int'(dbg_state), int'(RUN));

    // clken low for 5 cycles mid-symbol: everything frozen
    run_symbol(tone_v, 0, 2, "pre-freeze");
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 1'b1, 1'b1, tone_v, 1'b0, 1'b0, "freeze");
      chk("freeze dac_data", int'(dac_data), 10240);
      chk("freeze dac_valid", int'(dac_valid), 1);
      chk("freeze state", int'(dbg_state), int'(RUN));
    end
    run_symbol(tone_v, 3, 7, "post-freeze");

    // Asynchronous reset mid-symbol
    run_symbol(vecs[2], 0, 2, "pre-reset");
    nco_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async reset dac_data", int'(dac_data), MIDSCALE);
    chk("async reset dac_valid", int'(dac_valid), 0);
    chk("async reset state", int'(dbg_state), int'(IDLE));
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;

    run_symbol(vecs[9], 0, 7, "after reset");
    for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 1'b0, mute_v, 1'b0, 1'b0, "drain");
    chk("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
